turn_controller: RTL
====================

Name: turn_controller

Overview:
Game turn sequencer placed between the move sources and the board datapath. Player 0 uses local switches and a confirm button. Player 1 uses the UART receiver's decoded jugada/confirmacion/nuevo_dato outputs. The block arbitrates strictly by turn, enforces a per-turn countdown, and issues each confirmed column to the board logic over a valid/ready handshake. It then sequences the next turn, or ends the game, based on the board's result.

Parameters:
CLK_FREQ, 50_000_000, clk frequency in Hz; sets the 1 s tick prescaler.
TURN_SECONDS, 10, countdown loaded at the start of each turn (must be 1..15).
NUM_COLS, 7, legal columns are 0..NUM_COLS-1 (must be <= 8).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; starts or restarts a game
local_col  in  3  player 0 column selection (synchronised upstream)
local_confirm  in  1  one-cycle pulse; player 0 confirms local_col
uart_jugada  in  3  player 1 column from the UART decoder
uart_confirmacion  in  1  player 1 confirm bit, qualified by uart_nuevo_dato
uart_nuevo_dato  in  1  one-cycle strobe; UART fields valid
move_valid  out  1  move offered to the board
move_col  out  3  column of the offered move
move_player  out  1  player of the offered move
move_ready  in  1  board accepts the move
board_done  in  1  one-cycle pulse; board result valid
board_ok  in  1  move placed (0 = column full, illegal)
board_win  in  1  move produced a win
board_full  in  1  board full after the move
current_player  out  1  player whose turn it is
selected_col  out  3  preview column of the current player
seconds_left  out  4  remaining turn seconds
game_active  out  1  high from start until game end
winner  out  2  0 none, 1 player0, 2 player1, 3 draw
timeout_pulse  out  1  one-cycle pulse when a turn expires

Behaviour:
- Reset values: all outputs 0 and state IDLE. Prescaler and all registers are cleared asynchronously. A reset mid-handshake drops move_valid immediately.
- States: IDLE, WAIT_MOVE, ISSUE, WAIT_BOARD, GAME_END.
- IDLE or GAME_END + start:
  - Go to WAIT_MOVE.
  - Clear current_player, winner and selected_col.
  - Load seconds_left = TURN_SECONDS, clear the prescaler, set game_active = 1.
- start is ignored in all other states.
- WAIT_MOVE input handling:
  - Only the current player's source is sampled. Events from the other source are dropped, not buffered.
  - Player 1: uart_nuevo_dato with uart_confirmacion = 0 updates selected_col only (preview).
  - Player 1: uart_nuevo_dato with uart_confirmacion = 1 confirms uart_jugada.
  - Player 0: selected_col follows local_col every cycle. local_confirm confirms local_col.
  - A confirmed column >= NUM_COLS is ignored, with no state change.
- WAIT_MOVE, valid confirm: move_col <= column, move_player <= current_player, move_valid <= 1, go to ISSUE. move_valid is visible 1 cycle after the confirm.
- WAIT_MOVE timer:
  - The prescaler generates a tick every CLK_FREQ cycles. Each tick decrements seconds_left, saturating at 0.
  - When seconds_left = 0 with no valid confirm in that cycle: pulse timeout_pulse, toggle current_player, reload TURN_SECONDS, stay in WAIT_MOVE.
  - A confirm in the same cycle as expiry wins: no timeout.
- ISSUE:
  - move_valid, move_col and move_player are held stable until move_valid & move_ready.
  - On that cycle move_valid drops next cycle; go to WAIT_BOARD.
  - move_ready may be held high permanently, giving a 1-cycle ISSUE.
- Timer freeze: the timer and prescaler are frozen in ISSUE and WAIT_BOARD.
- WAIT_BOARD, on board_done, checked in priority order:
  1. board_win: winner <= current_player + 1; go to GAME_END.
  2. board_ok & board_full: winner <= 3; go to GAME_END.
  3. !board_ok: return to WAIT_MOVE with the same player; the timer resumes without reload.
  4. Otherwise: toggle current_player, reload the timer, clear the prescaler, go to WAIT_MOVE.
- GAME_END: game_active = 0, winner held, seconds_left frozen.
- board_done outside WAIT_BOARD and move_ready outside ISSUE are ignored.

Test Plan:
- rst pulse while in ISSUE with move_ready = 0 → move_valid, game_active, winner, current_player and seconds_left all read 0 immediately, and the state is IDLE.
- start; local_confirm with local_col = 3; move_ready = 1; board_done with board_ok = 1 → one cycle of move_valid with move_col = 3, move_player = 0; then current_player = 1 and seconds_left = 10.
- Player 1's turn:
  - uart_nuevo_dato with jugada = 5, confirmacion = 0 → selected_col = 5 and no move.
  - Then jugada = 7 with confirmacion = 1 → ignored (NUM_COLS = 7).
  - Then jugada = 2 with confirmacion = 1 → move_col = 2, move_player = 1.
  - local_confirm during player 1's turn → no effect.
- CLK_FREQ = 10, TURN_SECONDS = 3, no input → seconds_left steps 3, 2, 1, 0 at 10-cycle intervals, then timeout_pulse for 1 cycle, current_player toggles and seconds_left = 3. A confirm in the same cycle as expiry → move issued, no timeout_pulse.
- move_ready held low 5 cycles while local_col changes → move_col stays constant and move_valid stays high for 5 cycles.
- board_done with board_ok = 0 → same player, timer continues. board_done with board_win = 1 for player 1 → winner = 2, game_active = 0. board_full = 1 → winner = 3. start then restarts the game with winner = 0 and current_player = 0.

Source files
------------

// File: rtl/turn_controller.sv
// Turn sequencer between the two move sources and the board datapath.
// Arbitrates by turn, runs the per-turn countdown and hands confirmed moves to the board.
module turn_controller #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int TURN_SECONDS = 10,
  parameter int NUM_COLS     = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] local_col,
  input  logic       local_confirm,
  input  logic [2:0] uart_jugada,
  input  logic       uart_confirmacion,
  input  logic       uart_nuevo_dato,
  output logic       move_valid,
  output logic [2:0] move_col,
  output logic       move_player,
  input  logic       move_ready,
  input  logic       board_done,
  input  logic       board_ok,
  input  logic       board_win,
  input  logic       board_full,
  output logic       current_player,
  output logic [2:0] selected_col,
  output logic [3:0] seconds_left,
  output logic       game_active,
  output logic [1:0] winner,
  output logic       timeout_pulse
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);
  localparam logic [3:0]    TURN_LOAD = 4'(TURN_SECONDS);
  localparam logic [3:0]    COLS      = 4'(NUM_COLS);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_MOVE  = 3'd1,
    ISSUE      = 3'd2,
    WAIT_BOARD = 3'd3,
    GAME_END   = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic          player_n;
  logic [2:0]    sel_n;
  logic [3:0]    secs_n;
  logic          active_n;
  logic [1:0]    winner_n;
  logic          timeout_n;
  logic          valid_n;
  logic [2:0]    col_n;
  logic          mplayer_n;

  logic          src_confirm;
  logic [2:0]    src_col;
  logic          col_legal;
  logic          tick;
  logic [PW-1:0] presc_adv;
  logic [3:0]    secs_adv;

  // Only the source belonging to the player on turn is ever looked at.
  assign src_confirm = current_player ? (uart_nuevo_dato & uart_confirmacion) : local_confirm;
  assign src_col     = current_player ? uart_jugada : local_col;
  assign col_legal   = ({1'b0, src_col} < COLS);
  assign tick        = (presc == PRESC_MAX);
  assign presc_adv   = tick ? '0 : presc + PW'(1);
  assign secs_adv    = (tick && seconds_left != 4'd0) ? seconds_left - 4'd1 : seconds_left;

  always_comb begin
    state_n   = state;
    presc_n   = presc;
    player_n  = current_player;
    sel_n     = selected_col;
    secs_n    = seconds_left;
    active_n  = game_active;
    winner_n  = winner;
    timeout_n = 1'b0;
    valid_n   = move_valid;
    col_n     = move_col;
    mplayer_n = move_player;

    case (state)
      IDLE, GAME_END: begin
        if (start) begin
          state_n  = WAIT_MOVE;
          player_n = 1'b0;
          winner_n = 2'd0;
          sel_n    = 3'd0;
          secs_n   = TURN_LOAD;
          presc_n  = '0;
          active_n = 1'b1;
        end
      end

      WAIT_MOVE: begin
        if (!current_player) begin
          sel_n = local_col;
        end else if (uart_nuevo_dato && !uart_confirmacion) begin
          sel_n = uart_jugada;
        end

        // A legal confirm beats an expiry in the same cycle; the timer keeps running that cycle.
        if (src_confirm && col_legal) begin
          valid_n   = 1'b1;
          col_n     = src_col;
          mplayer_n = current_player;
          state_n   = ISSUE;
          presc_n   = presc_adv;
          secs_n    = secs_adv;
        end else if (seconds_left == 4'd0) begin
          timeout_n = 1'b1;
          player_n  = ~current_player;
          secs_n    = TURN_LOAD;
          presc_n   = '0;
        end else begin
          presc_n = presc_adv;
          secs_n  = secs_adv;
        end
      end

      ISSUE: begin
        if (move_ready) begin
          valid_n = 1'b0;
          state_n = WAIT_BOARD;
        end
      end

      WAIT_BOARD: begin
        if (board_done) begin
          if (board_win) begin
            winner_n = {1'b0, current_player} + 2'd1;
            active_n = 1'b0;
            state_n  = GAME_END;
          end else if (board_ok && board_full) begin
            winner_n = 2'd3;
            active_n = 1'b0;
            state_n  = GAME_END;
          end else if (!board_ok) begin
            state_n = WAIT_MOVE;
          end else begin
            player_n = ~current_player;
            secs_n   = TURN_LOAD;
            presc_n  = '0;
            state_n  = WAIT_MOVE;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      presc          <= '0;
      current_player <= 1'b0;
      selected_col   <= 3'd0;
      seconds_left   <= 4'd0;
      game_active    <= 1'b0;
      winner         <= 2'd0;
      timeout_pulse  <= 1'b0;
      move_valid     <= 1'b0;
      move_col       <= 3'd0;
      move_player    <= 1'b0;
    end else begin
      state          <= state_n;
      presc          <= presc_n;
      current_player <= player_n;
      selected_col   <= sel_n;
      seconds_left   <= secs_n;
      game_active    <= active_n;
      winner         <= winner_n;
      timeout_pulse  <= timeout_n;
      move_valid     <= valid_n;
      move_col       <= col_n;
      move_player    <= mplayer_n;
    end
  end

endmodule
